// File: rtl/subcore_launcher.sv
// rtl/subcore_launcher.sv - parent-side launch/join controller for CORE_NUM child fetch stages
// Optional per-child RUN-cycle counters (run_cycles) when SUBCORE_RUNCNT_EN is defined.
module subcore_launcher #(
  parameter int CORE_NUM = 4,
  parameter int CID_W    = 2,
  parameter int PC_W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_join,
  input  logic [CID_W-1:0]         cmd_core,
  input  logic [PC_W-1:0]          cmd_pc,
  output logic [CORE_NUM-1:0]      child_interlock,
  output logic [CORE_NUM-1:0]      child_exec_requested,
  output logic [PC_W*CORE_NUM-1:0] child_requested_pc,
  input  logic [CORE_NUM-1:0]      child_done,
  output logic [CORE_NUM-1:0]      busy,
  output logic                     join_valid,
  output logic [CID_W-1:0]         join_core,
  output logic                     parent_stall
`ifdef SUBCORE_RUNCNT_EN
  ,
  output logic [32*CORE_NUM-1:0]   run_cycles
`endif
);

  localparam logic [1:0] ST_HALTED = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;

  logic [CORE_NUM-1:0][1:0]      state_q, state_d;
  logic [CORE_NUM-1:0][PC_W-1:0] pc_q, pc_d;
  logic                          pend_q, pend_d;
  logic [CID_W-1:0]              pend_id_q, pend_id_d;
  logic                          cmd_halted, pend_halted, cmd_accept;
  logic [CORE_NUM-1:0]           launch_hit;

  // Ids with no matching child fall through as "halted": launches vanish, joins complete.
  always_comb begin
    cmd_halted  = 1'b1;
    pend_halted = 1'b1;
    for (int i = 0; i < CORE_NUM; i++) begin
      if (cmd_core == CID_W'(i))  cmd_halted  = (state_q[i] == ST_HALTED);
      if (pend_id_q == CID_W'(i)) pend_halted = (state_q[i] == ST_HALTED);
    end
  end

  always_comb begin
    cmd_ready    = !rst && !pend_q && (cmd_join || cmd_halted);
    cmd_accept   = cmd_valid && cmd_ready;
    join_valid   = !rst && pend_q && pend_halted;
    join_core    = pend_id_q;
    parent_stall = pend_q;
    pend_d       = pend_q;
    pend_id_d    = pend_id_q;
    if (join_valid) pend_d = 1'b0;
    if (cmd_accept && cmd_join) begin
      pend_d    = 1'b1;
      pend_id_d = cmd_core;
    end
  end

  always_comb begin
    for (int i = 0; i < CORE_NUM; i++) begin
      launch_hit[i] = cmd_accept && !cmd_join && (cmd_core == CID_W'(i));
      state_d[i]    = state_q[i];
      pc_d[i]       = pc_q[i];
      case (state_q[i])
        ST_HALTED: if (launch_hit[i]) begin
          state_d[i] = ST_REQ;
          pc_d[i]    = cmd_pc;
        end
        ST_REQ:    state_d[i] = ST_RUN;
        ST_RUN:    if (child_done[i]) state_d[i] = ST_HALTED;
        default:   state_d[i] = ST_HALTED;
      endcase
      child_interlock[i]      = (state_q[i] != ST_RUN);
      child_exec_requested[i] = (state_q[i] == ST_REQ);
      busy[i]                 = (state_q[i] != ST_HALTED);
    end
  end

  assign child_requested_pc = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= '0;
      pc_q      <= '0;
      pend_q    <= 1'b0;
      pend_id_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_id_q <= pend_id_d;
    end
  end

`ifdef SUBCORE_RUNCNT_EN
  logic [CORE_NUM-1:0][31:0] cnt_q, cnt_d;

  always_comb begin
    for (int i = 0; i < CORE_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
      if (launch_hit[i])
        cnt_d[i] = '0;
      else if (state_q[i] == ST_RUN && cnt_q[i] != 32'hFFFF_FFFF)
        cnt_d[i] = cnt_q[i] + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign run_cycles = cnt_q;
`endif

endmodule
